// File: rtl/qpl_blk_sched.sv
// Block-allocation scheduler: free-list FIFO of block IDs shared among CHANS writers via round-robin.
// Optional build macro QPL_SCHED_AUX_PRIO_EN gives aux requests strict priority over base requests.
module qpl_blk_sched #(
  parameter int CHANS   = 2,
  parameter int BLOCK_W = 8,
  parameter int ADDR_W  = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic [CHANS-1:0]               i_req,
  input  logic [CHANS-1:0]               i_req_aux,
  input  logic                           i_rel_vld,
  input  logic [BLOCK_W-1:0]             i_rel_id,
  output logic                           o_init_done,
  output logic                           o_blk_full,
  output logic [BLOCK_W:0]               o_blk_avail,
  output logic [CHANS-1:0]               o_blk_base_we,
  output logic [CHANS-1:0]               o_blk_aux_we,
  output logic [CHANS-1:0][ADDR_W-1:0]   o_blk_base_addr,
  output logic [CHANS-1:0][ADDR_W-1:0]   o_blk_aux_addr,
  output logic                           o_err
);

  localparam int DEPTH = 1 << BLOCK_W;
  localparam int CH_W  = $clog2(CHANS);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state, state_nxt;
  logic [BLOCK_W-1:0]  head, tail;
  logic [BLOCK_W:0]    count;
  logic [CH_W-1:0]     rr_ptr;
  logic [CHANS-1:0]    last_gnt;
  logic [BLOCK_W-1:0]  mem [DEPTH];

  logic [CHANS-1:0]    elig, pick;
  logic                gnt_vld, gnt_aux;
  logic [CH_W-1:0]     gnt_ch;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                init_wr, push, rel_err;

  // rr_ptr holds the first channel to consider; the previous grantee is masked for one cycle
  always_comb begin
    state_nxt = state;
    init_wr   = 1'b0;
    push      = 1'b0;
    rel_err   = 1'b0;
    elig      = '0;
    pick      = '0;
    gnt_vld   = 1'b0;
    gnt_ch    = '0;
    case (state)
      S_INIT: begin
        init_wr = 1'b1;
        if (i_rel_vld) rel_err = 1'b1;
        if (tail == BLOCK_W'(DEPTH - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_rel_vld) begin
          if (count == (BLOCK_W+1)'(DEPTH)) rel_err = 1'b1;
          else                              push    = 1'b1;
        end
        if (count != '0) elig = i_req & ~last_gnt;
`ifdef QPL_SCHED_AUX_PRIO_EN
        pick = (|(elig & i_req_aux)) ? (elig & i_req_aux) : elig;
`else
        pick = elig;
`endif
        for (int i = 0; i < CHANS; i++) begin
          if (!gnt_vld && pick[(int'(rr_ptr) + i) % CHANS]) begin
            gnt_vld = 1'b1;
            gnt_ch  = CH_W'((int'(rr_ptr) + i) % CHANS);
          end
        end
      end
      default: state_nxt = S_INIT;
    endcase
    gnt_aux  = i_req_aux[gnt_ch];
    gnt_addr = ADDR_W'(mem[head]) << (ADDR_W - BLOCK_W);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state           <= S_INIT;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      rr_ptr          <= '0;
      last_gnt        <= '0;
      o_blk_base_we   <= '0;
      o_blk_aux_we    <= '0;
      o_blk_base_addr <= '0;
      o_blk_aux_addr  <= '0;
      o_err           <= 1'b0;
    end else begin
      state <= state_nxt;
      if (init_wr || push) tail <= tail + BLOCK_W'(1);
      if (gnt_vld)         head <= head + BLOCK_W'(1);
      case ({init_wr | push, gnt_vld})
        2'b10:   count <= count + (BLOCK_W+1)'(1);
        2'b01:   count <= count - (BLOCK_W+1)'(1);
        default: count <= count;
      endcase
      if (rel_err) o_err <= 1'b1;
      o_blk_base_we <= '0;
      o_blk_aux_we  <= '0;
      last_gnt      <= '0;
      if (gnt_vld) begin
        rr_ptr           <= (gnt_ch == CH_W'(CHANS - 1)) ? '0 : gnt_ch + CH_W'(1);
        last_gnt[gnt_ch] <= 1'b1;
        if (gnt_aux) begin
          o_blk_aux_we[gnt_ch]   <= 1'b1;
          o_blk_aux_addr[gnt_ch] <= gnt_addr;
        end else begin
          o_blk_base_we[gnt_ch]   <= 1'b1;
          o_blk_base_addr[gnt_ch] <= gnt_addr;
        end
      end
    end
  end

  // During INIT the tail pointer doubles as the ID being written
  always_ff @(posedge i_clk) begin
    if (init_wr)   mem[tail] <= tail;
    else if (push) mem[tail] <= i_rel_id;
  end

  assign o_init_done = (state == S_RUN);
  assign o_blk_full  = (count == '0);
  assign o_blk_avail = count;

endmodule

// File: tb/tb_qpl_blk_sched.sv
// Scoreboard bench for qpl_blk_sched: directed stimulus pushes expected grants, a monitor checks them.
module tb_qpl_blk_sched;

  localparam int CHANS   = 2;
  localparam int BLOCK_W = 8;
  localparam int ADDR_W  = 16;

  logic                         clk = 1'b0;
  logic                         rstn;
  logic [CHANS-1:0]             req, req_aux;
  logic                         rel_vld;
  logic [BLOCK_W-1:0]           rel_id;
  logic                         init_done, blk_full, err;
  logic [BLOCK_W:0]             blk_avail;
  logic [CHANS-1:0]             base_we, aux_we;
  logic [CHANS-1:0][ADDR_W-1:0] base_addr, aux_addr;

  typedef struct {
    int          ch;
    bit          aux;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   fail_count = 0;

  qpl_blk_sched #(.CHANS(CHANS), .BLOCK_W(BLOCK_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_req_aux(req_aux),
    .i_rel_vld(rel_vld), .i_rel_id(rel_id),
    .o_init_done(init_done), .o_blk_full(blk_full), .o_blk_avail(blk_avail),
    .o_blk_base_we(base_we), .o_blk_aux_we(aux_we),
    .o_blk_base_addr(base_addr), .o_blk_aux_addr(aux_addr), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [CHANS-1:0] r, input logic [CHANS-1:0] a);
    req     = r;
    req_aux = a;
  endtask

  task automatic expectGrant(input int ch, input bit aux, input logic [15:0] addr);
    exp_t e;
    e.ch = ch; e.aux = aux; e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic waitInit();
    int cyc = 0;
    while (!init_done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("init_latency", cyc, 256);
    checkOutput("init_avail", 32'(blk_avail), 256);
    checkOutput("init_full", 32'(blk_full), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_init_done"}, 32'(init_done), 0);
    checkOutput({tag, "_full"}, 32'(blk_full), 1);
    checkOutput({tag, "_avail"}, 32'(blk_avail), 0);
    checkOutput({tag, "_we"}, 32'({base_we, aux_we}), 0);
    checkOutput({tag, "_addr"}, 32'(base_addr) | 32'(aux_addr), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
  endtask

  // Monitor: every strobe must match the oldest expected grant
  always @(negedge clk) begin
    if (rstn && (|base_we || |aux_we)) begin
      int   ch;
      bit   aux;
      exp_t e;
      ch  = 0;
      aux = |aux_we;
      for (int c = 0; c < CHANS; c++) if (base_we[c] || aux_we[c]) ch = c;
      tests_run++;
      if ($countones({base_we, aux_we}) != 1) begin
        fail_count++;
        $display("[TB] FAIL grant_onehot: got we 0x%0h, expected one bit", {base_we, aux_we});
      end else if (exp_q.size() == 0) begin
        fail_count++;
        $display("[TB] FAIL unexpected_grant: got ch%0d aux=%0b, expected no grant", ch, aux);
      end else begin
        logic [15:0] got_addr;
        e = exp_q.pop_front();
        got_addr = aux ? aux_addr[ch] : base_addr[ch];
        if (ch != e.ch || aux != e.aux || got_addr !== e.addr) begin
          fail_count++;
          $display("[TB] FAIL grant: got ch%0d aux=%0b addr=0x%04h, expected ch%0d aux=%0b addr=0x%04h",
                   ch, aux, got_addr, e.ch, e.aux, e.addr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    rstn = 1'b0; rel_vld = 1'b0; rel_id = '0;
    applyStimulus('0, '0);
    #12;
    checkResetValues("reset");
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    waitInit();

    // Single channel: base then aux
    applyStimulus(2'b01, 2'b00);
    expectGrant(0, 1'b0, 16'h0000);
    @(posedge clk); #1;
    applyStimulus(2'b00, 2'b00);
    @(posedge clk); #1;
    applyStimulus(2'b01, 2'b01);
    expectGrant(0, 1'b1, 16'h0100);
    @(posedge clk); #1;
    applyStimulus(2'b00, 2'b00);
    checkOutput("single_avail", 32'(blk_avail), 254);
    checkOutput("base_addr_hold", 32'(base_addr[0]), 32'h0000);

    // Contention: rr pointer sits at ch1 after the ch0 grants
    for (int k = 2; k < 8; k++) expectGrant((k % 2 == 0) ? 1 : 0, 1'b0, 16'(k << 8));
    applyStimulus(2'b11, 2'b00);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("contention_avail", 32'(blk_avail), 248);

    // Exhaustion: keep both requests held until the pool is empty
    for (int k = 8; k < 256; k++) expectGrant((k % 2 == 0) ? 1 : 0, 1'b0, 16'(k << 8));
    cyc = 0;
    while (!blk_full && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("exhaust_full", 32'(blk_full), 1);
    checkOutput("exhaust_avail", 32'(blk_avail), 0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("no_grant_when_full", 32'({base_we, aux_we}), 0);
    end
    rel_vld = 1'b1; rel_id = 8'h37;
    expectGrant(1, 1'b0, 16'h3700);
    @(posedge clk); #1;
    rel_vld = 1'b0;
    checkOutput("release_avail", 32'(blk_avail), 1);
    checkOutput("release_full", 32'(blk_full), 0);
    @(posedge clk); #1;
    checkOutput("regrant_full", 32'(blk_full), 1);
    applyStimulus(2'b00, 2'b00);
    @(posedge clk); #1;

    // Fresh pool: error on overfull release, then priority
    rstn = 1'b0;
    #1;
    checkResetValues("reset2");
    @(negedge clk);
    rstn = 1'b1;
    waitInit();
    rel_vld = 1'b1; rel_id = 8'h05;
    @(posedge clk); #1;
    rel_vld = 1'b0;
    checkOutput("overfull_err", 32'(err), 1);
    checkOutput("overfull_avail", 32'(blk_avail), 256);

`ifdef QPL_SCHED_AUX_PRIO_EN
    expectGrant(1, 1'b1, 16'h0000);
    expectGrant(0, 1'b0, 16'h0100);
    applyStimulus(2'b11, 2'b10);
    @(posedge clk); #1;
    applyStimulus(2'b01, 2'b00);
`else
    expectGrant(0, 1'b0, 16'h0000);
    expectGrant(1, 1'b1, 16'h0100);
    applyStimulus(2'b11, 2'b10);
    @(posedge clk); #1;
    applyStimulus(2'b10, 2'b10);
`endif
    @(posedge clk); #1;
    applyStimulus(2'b00, 2'b00);
    @(posedge clk); #1;

    // Reset while a grant strobe is on the outputs
    expectGrant(0, 1'b0, 16'h0200);
    applyStimulus(2'b01, 2'b00);
    @(posedge clk);
    @(negedge clk); #2;
    checkOutput("pre_reset_we", 32'(base_we), 1);
    rstn = 1'b0;
    #1;
    checkResetValues("midreset");
    applyStimulus(2'b00, 2'b00);
    @(posedge clk); #1;
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
